// File: rtl/split_burst.sv
// Replays burst descriptors {burst_len, base_addr} as a per-beat address stream,
// tagging the final beat of each burst with last and handing over to the next burst without a bubble.
module split_burst #(
    parameter int AddrWidth         = 64,
    parameter int DataWidthBytesLog = 6,
    parameter int BurstLenWidth     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [BurstLenWidth+AddrWidth-1:0] burst_dout,
    input  logic                               burst_empty_n,
    output logic                               burst_read,
    output logic [AddrWidth:0]                 addr_din,
    input  logic                               addr_full_n,
    output logic                               addr_write,
    output logic                               idle
);

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [AddrWidth-1:0] Stride = AddrWidth'(1) << DataWidthBytesLog;

    state_t                   state_q, state_d;
    logic [AddrWidth-1:0]     cur_addr_q, cur_addr_d;
    logic [BurstLenWidth-1:0] remaining_q, remaining_d;

    logic active;
    logic last_beat;
    logic beat_done;

    assign active     = (state_q == EXPAND);
    assign last_beat  = (remaining_q == '0);
    assign addr_write = active & addr_full_n;
    assign beat_done  = addr_write & last_beat;
    // A pop is allowed in the same cycle the final beat leaves, so bursts chain back to back.
    assign burst_read = burst_empty_n & (~active | beat_done);
    assign addr_din   = {last_beat, cur_addr_q};
    assign idle       = ~active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        if (burst_read) begin
            state_d     = EXPAND;
            cur_addr_d  = burst_dout[AddrWidth-1:0];
            remaining_d = burst_dout[AddrWidth +: BurstLenWidth];
        end else if (addr_write && !last_beat) begin
            // Address wraps naturally; low offset bits of a misaligned base are preserved.
            cur_addr_d  = cur_addr_q + Stride;
            remaining_d = remaining_q - 1'b1;
        end else if (beat_done) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_split_burst.sv
// Directed bench for split_burst: a small descriptor queue feeds the block and
// every beat written is captured with its cycle number for comparison against hand-computed values.
module tb_split_burst;

    localparam int AW = 64;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW+AW-1:0] burst_dout;
    logic          burst_empty_n;
    logic          burst_read;
    logic [AW:0]   addr_din;
    logic          addr_full_n;
    logic          addr_write;
    logic          idle;

    split_burst #(.AddrWidth(AW), .DataWidthBytesLog(6), .BurstLenWidth(BW)) dut (
        .clk(clk), .rst(rst), .burst_dout(burst_dout), .burst_empty_n(burst_empty_n),
        .burst_read(burst_read), .addr_din(addr_din), .addr_full_n(addr_full_n),
        .addr_write(addr_write), .idle(idle)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [BW+AW-1:0] desc_q[$];
    logic [AW:0]      cap_d[$];
    int               cap_cyc[$];
    int               rd_cyc[$];
    logic             last_w, last_r;
    logic [AW:0]      last_d;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        burst_empty_n = (desc_q.size() != 0);
        burst_dout    = (desc_q.size() != 0) ? desc_q[0] : '0;
    endtask

    task automatic push(input logic [BW-1:0] len, input logic [AW-1:0] base);
        desc_q.push_back({len, base});
        refresh();
    endtask

    task automatic clear_caps();
        cap_d.delete();
        cap_cyc.delete();
        rd_cyc.delete();
    endtask

    // One clock: sample settled outputs, apply the edge, update the descriptor queue.
    task automatic tick();
        #1;
        last_w = addr_write;
        last_r = burst_read;
        last_d = addr_din;
        if (last_w) begin
            cap_d.push_back(last_d);
            cap_cyc.push_back(cyc);
        end
        if (last_r) begin
            rd_cyc.push_back(cyc);
            if (desc_q.size() != 0) void'(desc_q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        refresh();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [127:0] beat(input logic lst, input logic [AW-1:0] a);
        return {63'b0, lst, a};
    endfunction

    initial begin
        rst = 1'b1;
        addr_full_n = 1'b1;
        refresh();
        #2;
        check("rst_addr_write", addr_write, 1'b0);
        check("rst_burst_read", burst_read, 1'b0);
        check("rst_addr_din", addr_din, beat(1'b1, 64'h0));
        check("rst_idle", idle, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        run(2);
        check("idle_after_release", idle, 1'b1);

        // Basic expansion
        clear_caps();
        push(8'd3, 64'h1000);
        run(7);
        check("basic_count", cap_d.size(), 4);
        if (cap_d.size() == 4) begin
            check("basic_b0", cap_d[0], beat(1'b0, 64'h1000));
            check("basic_b1", cap_d[1], beat(1'b0, 64'h1040));
            check("basic_b2", cap_d[2], beat(1'b0, 64'h1080));
            check("basic_b3", cap_d[3], beat(1'b1, 64'h10C0));
            check("basic_consecutive", cap_cyc[3] - cap_cyc[0], 3);
            check("basic_latency", cap_cyc[0] - rd_cyc[0], 1);
        end
        check("basic_idle", idle, 1'b1);

        // Back-to-back single-beat bursts
        clear_caps();
        push(8'd0, 64'h0);
        push(8'd0, 64'h200);
        push(8'd2, 64'h400);
        run(8);
        check("b2b_count", cap_d.size(), 5);
        check("b2b_reads", rd_cyc.size(), 3);
        if (cap_d.size() == 5 && rd_cyc.size() == 3) begin
            check("b2b_w0", cap_d[0], beat(1'b1, 64'h0));
            check("b2b_w1", cap_d[1], beat(1'b1, 64'h200));
            check("b2b_w2", cap_d[2], beat(1'b0, 64'h400));
            check("b2b_w3", cap_d[3], beat(1'b0, 64'h440));
            check("b2b_w4", cap_d[4], beat(1'b1, 64'h480));
            check("b2b_consecutive", cap_cyc[4] - cap_cyc[0], 4);
            check("b2b_rd1", rd_cyc[1] - rd_cyc[0], 1);
            check("b2b_rd2", rd_cyc[2] - rd_cyc[0], 2);
            check("b2b_first_write", cap_cyc[0] - rd_cyc[0], 1);
        end
        check("b2b_idle", idle, 1'b1);

        // Backpressure after beat 0x1040
        clear_caps();
        push(8'd3, 64'h1000);
        run(3);
        addr_full_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_write", last_w, 1'b0);
            check("stall_din_held", last_d, beat(1'b0, 64'h1080));
        end
        addr_full_n = 1'b1;
        run(4);
        check("bp_count", cap_d.size(), 4);
        if (cap_d.size() == 4) begin
            check("bp_b1", cap_d[1], beat(1'b0, 64'h1040));
            check("bp_b2", cap_d[2], beat(1'b0, 64'h1080));
            check("bp_b3", cap_d[3], beat(1'b1, 64'h10C0));
            check("bp_gap", cap_cyc[2] - cap_cyc[1], 4);
        end

        // Address wrap-around
        clear_caps();
        push(8'd1, 64'hFFFF_FFFF_FFFF_FFC0);
        run(4);
        check("wrap_count", cap_d.size(), 2);
        if (cap_d.size() == 2) begin
            check("wrap_b0", cap_d[0], beat(1'b0, 64'hFFFF_FFFF_FFFF_FFC0));
            check("wrap_b1", cap_d[1], beat(1'b1, 64'h0));
        end

        // Maximum length
        clear_caps();
        push(8'd255, 64'h0);
        run(262);
        check("max_count", cap_d.size(), 256);
        if (cap_d.size() == 256) begin
            int lasts = 0;
            for (int i = 0; i < 256; i++) if (cap_d[i][AW]) lasts++;
            check("max_last_count", lasts, 1);
            check("max_final", cap_d[255], beat(1'b1, 64'h3FC0));
            check("max_b128", cap_d[128], beat(1'b0, 64'h2000));
            check("max_consecutive", cap_cyc[255] - cap_cyc[0], 255);
        end

        // Reset mid-burst
        clear_caps();
        push(8'd7, 64'h0);
        run(3);
        check("pre_rst_beats", cap_d.size(), 2);
        rst = 1'b1;
        #1;
        check("async_rst_write", addr_write, 1'b0);
        check("async_rst_idle", idle, 1'b1);
        check("async_rst_din", addr_din, beat(1'b1, 64'h0));
        run(2);
        rst = 1'b0;
        run(1);
        check("post_rst_idle", idle, 1'b1);
        check("post_rst_no_write", last_w, 1'b0);
        clear_caps();
        push(8'd0, 64'h80);
        run(5);
        check("post_rst_count", cap_d.size(), 1);
        if (cap_d.size() == 1) check("post_rst_beat", cap_d[0], beat(1'b1, 64'h80));
        check("final_idle", idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/split_burst.md
# split_burst

Expands a stream of burst descriptors `{burst_len, base_addr}` back into the per-beat address stream they encode. It is the inverse of the burst detector in the async memory-map path. It sits on the memory side, where a coalesced request must be replayed one beat at a time. One descriptor with length field L produces exactly L+1 consecutive beat addresses, spaced by the data width, and the final beat is tagged `last`.

## Interface

Parameters:
- `AddrWidth`, 64, byte-address width.
- `DataWidthBytesLog`, 6, log2 of bytes per beat; sets the address stride `1 << DataWidthBytesLog`.
- `BurstLenWidth`, 8, width of the length field; the field encodes beats minus one.

Ports:
- `clk`  in  1  clock; the block has a single clock domain.
- `rst`  in  1  asynchronous reset, active-high.
- `burst_dout`  in  BurstLenWidth+AddrWidth  descriptor `{burst_len, base_addr}`; `burst_len` is in the MSBs.
- `burst_empty_n`  in  1  descriptor FIFO is non-empty.
- `burst_read`  out  1  pops one descriptor.
- `addr_din`  out  AddrWidth+1  beat output `{last, addr}`.
- `addr_full_n`  in  1  output FIFO has space.
- `addr_write`  out  1  pushes one beat.
- `idle`  out  1  high when no burst is in progress.

## Operation

State registers:
- `active` (1 bit)
- `cur_addr` (AddrWidth bits)
- `remaining` (BurstLenWidth bits)

Two states, IDLE (`active`=0) and EXPAND (`active`=1).

Combinational outputs:
- `addr_write = active & addr_full_n`
- `addr_din = {remaining == 0, cur_addr}`
- `idle = !active`
- `beat_done = addr_write & (remaining == 0)`
- `burst_read = burst_empty_n & (!active | beat_done)`

Next-state rules, in priority order:
1. `burst_read`: load `cur_addr <= burst_dout[AddrWidth-1:0]`, `remaining <= burst_dout[MSBs]`, `active <= 1`. This applies even when the last beat of the previous burst is written in the same cycle (back-to-back hand-over).
2. Else `addr_write & remaining != 0`: `cur_addr <= cur_addr + (1 << DataWidthBytesLog)` and `remaining <= remaining - 1`.
3. Else `beat_done`: `active <= 0`. `cur_addr` and `remaining` hold.
4. Else: all state holds.

Arithmetic and width rules:
- Address addition wraps modulo 2^AddrWidth.
- Low address bits are not masked; a misaligned base keeps its offset on every beat.
- `remaining` never underflows, because decrement happens only when it is non-zero.
- Length field 0 gives one beat; the maximum `2^BurstLenWidth - 1` gives `2^BurstLenWidth` beats.

Boundary conditions:
- Output FIFO full: `addr_write` = 0 and all state holds. `addr_din` stays stable and no beat is lost or duplicated.
- Descriptor FIFO empty during the last beat: the block goes to IDLE and resumes as soon as `burst_empty_n` rises.
- Simultaneous last beat and new descriptor: both happen in the same cycle, with no bubble.
- `burst_read` never asserts while `burst_empty_n` = 0.

## Timing

- Reset (async, takes effect immediately):
  - `active` = 0, `cur_addr` = 0, `remaining` = 0.
  - Outputs: `addr_write` = 0, `burst_read` = 0, `addr_din = {1'b1, 0}`, `idle` = 1.
- Reset asserted mid-burst: the remaining beats are discarded and the block is IDLE on the next edge after release.
- Latency: a descriptor popped at edge t produces its first `addr_write` in cycle t+1, if `addr_full_n` is high.
- Throughput: one beat per cycle, sustained across burst boundaries, when the output has no backpressure.
- A burst of length field L with no stalls occupies L+1 consecutive write cycles.

## Test plan

- **Basic expansion.** DataWidthBytesLog=6. Push `{3, 0x1000}`. Expect writes of 0x1000, 0x1040, 0x1080, 0x10C0 on 4 consecutive cycles, with `last` = 0, 0, 0, 1. Then `idle` = 1.
- **Back-to-back single-beat bursts.** Push `{0, 0x0}`, `{0, 0x200}`, `{2, 0x400}` preloaded. Expect 5 writes on 5 consecutive cycles: 0x0(last), 0x200(last), 0x400, 0x440, 0x480(last). `burst_read` is high on cycles 0, 1 and 2 of the stream.
- **Backpressure.** During `{3, 0x1000}`, hold `addr_full_n` low for 3 cycles after beat 0x1040. Expect no writes during the stall, `addr_din` held at 0x1080, then 0x1080 and 0x10C0 with no loss and no duplicate.
- **Wrap-around.** AddrWidth=64. Push `{1, 0xFFFF_FFFF_FFFF_FFC0}`. Expect 0xFFFF_FFFF_FFFF_FFC0, then 0x0 with `last` = 1.
- **Maximum length.** Push `{255, 0x0}`. Expect exactly 256 writes, with the last beat at 0x3FC0 and `last` asserted only on the 256th write.
- **Reset mid-burst.** Assert `rst` asynchronously after 2 beats of `{7, 0x0}`. Expect `addr_write` = 0 and `idle` = 1 immediately. After release, push `{0, 0x80}`. Expect a single write of 0x80 with `last` = 1 and no residual beats.
